down_timer: RTL
===============

# down_timer

Loadable 16-bit down-counting timer, the counterpart to the team's free-running up counter: software or an upstream controller loads a count, starts it, and receives a one-cycle terminal-count pulse when the programmed number of enabled cycles has elapsed. It supports one-shot and periodic (auto-reload) modes. It sits beside the up counter in the timing block and drives event/interrupt logic with `TC`.

## Interface
- `WIDTH`, 16, counter and preset width in bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; one decrement per `clk` edge with `en`=1 while running.
- `load`  in  1  capture `preset` into reload register and `q`.
- `preset`  in  WIDTH  value loaded by `load`.
- `start`  in  1  begin counting from current `q`.
- `stop`  in  1  abort counting; `q` holds.
- `periodic`  in  1  mode select, sampled on the accepted `start` (1 = auto-reload).
- `q`  out  WIDTH  current count.
- `TC`  out  1  terminal-count pulse, exactly one cycle wide.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (one-shot expired).

## Operation
- States: IDLE, RUN, DONE. Reset: state IDLE; `q`=0, reload=0, mode=0, `TC`=0, `busy`=0, `done`=0.
- Per-edge priority: `reset` > `stop` > `load` > `start` > decrement.
- IDLE: `load` -> reload<=`preset`, `q`<=`preset`. `start` with `q`!=0 -> RUN, mode<=`periodic`. `start` with `q`==0 is ignored (stay IDLE, no `TC`).
- RUN, `en`=1:
  - `q`>1: `q`<=`q`-1.
  - `q`==1, one-shot: `q`<=0, `TC`<=1, go to DONE.
  - `q`==1, periodic: `q`<=reload, `TC`<=1, stay in RUN. `q` never shows 0.
- RUN, `en`=0: hold.
- RUN, `stop`: go to IDLE with `q` held. RUN, `load`: reload and `q`<=`preset`, stay in RUN, no `TC`. If that `preset` is 0 -> go to IDLE. `start` in RUN is ignored.
- DONE: `q`=0. `start` -> `q`<=reload, go to RUN (if reload==0, stay in DONE). `load` -> `q`<=`preset`, go to IDLE. `stop` -> IDLE.
- Arithmetic: unsigned, WIDTH bits. The decrement never wraps below 0. A loaded value N yields `TC` after exactly N enabled cycles. N=2^WIDTH-1 is the maximum period.

## Timing
- All outputs are registered. `busy`/`done` follow state and update on the edge that changes state.
- `start` accepted at edge k: `busy`=1 after k. The first decrement happens at the first edge >k with `en`=1. `en` in the start cycle is not counted.
- `TC` is high for the single cycle after the terminal edge, coincident with `q`=0 (one-shot) or `q`=reload (periodic). It returns to 0 on the next edge regardless of `en`.
- `stop` or `load` on the terminal edge wins: no `TC`.
- Asynchronous `reset` mid-RUN clears everything immediately, including a pending `TC`.

## Structure
- Shared package `timer_pkg`: state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`) and `TIMER_WIDTH_DEF`=16.
- Single module. State register, reload register, and count register live in one sequential process, with next-state and next-count logic in a combinational process.
- No sub-module required. The existing up counter is not reused because its reset is synchronous.

## Test plan
- Reset mid-RUN with `q`=5 -> `q`=0, `busy`=0, `TC`=0 immediately, before the next `clk` edge.
- `load` 3, `start`, `periodic`=0, `en`=1 continuous -> `q` 3,2,1,0. `TC`=1 only in the cycle with `q`=0. `done`=1, `busy`=0.
- `load` 4, periodic, `en` high every other cycle -> `TC` every 8 cycles. `q` sequence 4,3,2,1,4,… and never 0.
- `start` with `q`=0 -> stays IDLE, no `TC`. `start` in DONE after `load` 2 -> runs again, `TC` after 2 enabled cycles.
- `stop` asserted on the edge where `q`=1 and `en`=1 -> IDLE, `q`=1, no `TC`. `load` 7 at the same edge instead -> `q`=7, RUN, no `TC`.
- `load` 16'hFFFF, one-shot -> `TC` after exactly 65535 enabled cycles, with no wrap.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timing block: FSM state encoding and default widths.
package timer_pkg;

    localparam int unsigned TIMER_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } timer_state_e;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes; TC pulses one cycle
// after the enabled edge that consumes the last count.
module down_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] q,
    output logic             TC,
    output logic             busy,
    output logic             done
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    reload_d = preset;
                    count_d  = preset;
                end else if (start && (count_q != '0)) begin
                    state_d = ST_RUN;
                    mode_d  = periodic;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    reload_d = preset;
                    count_d  = preset;
                    if (preset == '0) begin
                        state_d = ST_IDLE;
                    end
                end else if (en) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
                        // A zero reload cannot sustain a period, so it expires like one-shot.
                        if (mode_q && (reload_q != '0)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    reload_d = preset;
                    count_d  = preset;
                    state_d  = ST_IDLE;
                end else if (start && (reload_q != '0)) begin
                    count_d = reload_q;
                    mode_d  = periodic;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            TC       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            TC       <= tc_d;
            busy     <= (state_d == ST_RUN);
            done     <= (state_d == ST_DONE);
        end
    end

    assign q = count_q;

endmodule
